// File: rtl/dmem_mmio_if.sv
// Core-side data bus plus the byte-wide TX sink handshake for dmem_mmio.
// The master side is the core (or bench); the slave side is the memory block.
interface dmem_mmio_if;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport master (
    output MemWrite, ALUResult, WriteData, tx_ready,
    input  ReadData, tx_valid, tx_data
  );

  modport slave (
    input  MemWrite, ALUResult, WriteData, tx_ready,
    output ReadData, tx_valid, tx_data
  );
endinterface

// File: rtl/dmem_mmio.sv
// Data-side memory subsystem: word RAM, free-running cycle timer and a byte
// TX FIFO draining to a ready/valid sink. Loads are combinational and see the
// state before the clock edge; stores land on the next rising edge.
module dmem_mmio #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input logic        clk,
  input logic        reset,
  dmem_mmio_if.slave bus
);
  localparam int RW = $clog2(RAM_WORDS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [31:0]   ram_r [RAM_WORDS];
  logic [31:0]   timer_r;
  logic [7:0]    fifo_r [FIFO_DEPTH];
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic          ovf_r;

  logic          mmio_s;
  logic [1:0]    reg_sel_s;
  logic [RW-1:0] ram_idx_s;
  logic          ram_we_s;
  logic          timer_we_s;
  logic          push_req_s;
  logic          status_we_s;
  logic          empty_s;
  logic          full_s;
  logic          pop_s;
  logic          push_ok_s;
  logic          ovf_set_s;
  logic [CW-1:0] count_nxt_s;
  logic [4:0]    cnt5_s;
  logic [31:0]   status_s;
  logic [31:0]   rdata_s;
  logic          unused_s;

  assign mmio_s    = bus.ALUResult[31];
  assign reg_sel_s = bus.ALUResult[3:2];
  assign ram_idx_s = bus.ALUResult[2 +: RW];
  // Byte-offset bits and upper address bits only alias; they carry no meaning here.
  assign unused_s  = ^{bus.ALUResult[1:0], bus.ALUResult[30:4]};

  // Store decode: route MemWrite to RAM or one of the MMIO registers.
  always_comb begin
    ram_we_s    = 1'b0;
    timer_we_s  = 1'b0;
    push_req_s  = 1'b0;
    status_we_s = 1'b0;
    if (bus.MemWrite) begin
      if (!mmio_s) begin
        ram_we_s = 1'b1;
      end else begin
        case (reg_sel_s)
          2'd0:    timer_we_s  = 1'b1;
          2'd1:    push_req_s  = 1'b1;
          2'd2:    status_we_s = 1'b1;
          default: ram_we_s    = 1'b0;
        endcase
      end
    end else begin
      ram_we_s = 1'b0;
    end
  end

  // FIFO flow control: a push into a full FIFO survives only if a pop frees a slot.
  always_comb begin
    empty_s     = (count_r == {CW{1'b0}});
    full_s      = (count_r == FULL_CNT);
    pop_s       = !empty_s && bus.tx_ready;
    push_ok_s   = push_req_s && (!full_s || pop_s);
    ovf_set_s   = push_req_s && !push_ok_s;
    count_nxt_s = count_r;
    case ({push_ok_s, pop_s})
      2'b10:   count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_nxt_s = count_r - {{(CW-1){1'b0}}, 1'b1};
      default: count_nxt_s = count_r;
    endcase
  end

  // RAM array: not reset, but a store coinciding with reset is suppressed.
  always_ff @(posedge clk) begin
    if (ram_we_s && !reset) begin
      ram_r[ram_idx_s] <= bus.WriteData;
    end
  end

  // Cycle timer: a software load wins over the increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_r <= 32'h0000_0000;
    end else if (timer_we_s) begin
      timer_r <= bus.WriteData;
    end else begin
      timer_r <= timer_r + 32'h0000_0001;
    end
  end

  // FIFO storage: data slots need no reset because the empty flag masks them.
  always_ff @(posedge clk) begin
    if (push_ok_s && !reset) begin
      fifo_r[tail_r] <= bus.WriteData[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow (set beats clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      if (push_ok_s) begin
        tail_r <= tail_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        head_r <= head_r + {{(AW-1){1'b0}}, 1'b1};
      end
      count_r <= count_nxt_s;
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (status_we_s) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // Load mux: RAM or MMIO register, zero for write-only and reserved slots.
  always_comb begin
    cnt5_s   = 5'(count_r);
    status_s = {24'h00_0000, cnt5_s, ovf_r, full_s, empty_s};
    rdata_s  = 32'h0000_0000;
    if (!mmio_s) begin
      rdata_s = ram_r[ram_idx_s];
    end else begin
      case (reg_sel_s)
        2'd0:    rdata_s = timer_r;
        2'd2:    rdata_s = status_s;
        default: rdata_s = 32'h0000_0000;
      endcase
    end
  end

  assign bus.ReadData = rdata_s;
  assign bus.tx_valid = !empty_s;
  assign bus.tx_data  = empty_s ? 8'h00 : fifo_r[head_r];
endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: stimulus tasks queue expected load values
// and expected TX bytes; one monitor on the falling edge pops and compares.
module tb_dmem_mmio;
  localparam logic [31:0] A_TIMER = 32'h8000_0000;
  localparam logic [31:0] A_TXD   = 32'h8000_0004;
  localparam logic [31:0] A_STAT  = 32'h8000_0008;
  localparam logic [31:0] A_RSV   = 32'h8000_000C;

  typedef struct {
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  dmem_mmio_if bus ();

  dmem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t       rd_q [$];
  logic [7:0] tx_q [$];
  int         total = 0;
  int         bad = 0;
  bit         chk_v = 1'b0;
  bit         end_chk = 1'b0;
  bit         end_done = 1'b0;
  logic       rst_v = 1'b1;
  logic       rdy_v = 1'b0;

  // One bus cycle; kind 0 checks ReadData, kind 1 checks {tx_valid, tx_data}, -1 none.
  task automatic cyc(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input int kind, input logic [31:0] ev, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset         = rst_v;
    bus.tx_ready  = rdy_v;
    bus.MemWrite  = we;
    bus.ALUResult = addr;
    bus.WriteData = wd;
    if (kind >= 0) begin
      e.kind = kind;
      e.val  = ev;
      e.name = nm;
      rd_q.push_back(e);
      chk_v = 1'b1;
    end else begin
      chk_v = 1'b0;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b1, a, d, -1, 32'h0, "");
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ev, input string nm);
    cyc(1'b0, a, 32'h0, 0, ev, nm);
  endtask

  task automatic lvl(input logic [31:0] ev, input string nm);
    cyc(1'b0, 32'h0, 32'h0, 1, ev, nm);
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 32'h0, -1, 32'h0, "");
  endtask

  // Push a byte that must later reach the sink.
  task automatic push(input logic [7:0] b);
    tx_q.push_back(b);
    wr(A_TXD, {24'h0, b});
  endtask

  // Push a byte expected to be dropped or discarded.
  task automatic pushx(input logic [7:0] b);
    wr(A_TXD, {24'h0, b});
  endtask

  // Monitor: compare loads/levels on request and every accepted TX byte.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    logic [7:0]  eb;
    if (chk_v) begin
      total++;
      if (rd_q.size() == 0) begin
        bad++;
        $display("FAIL rd_queue: got empty queue required an entry");
      end else begin
        e   = rd_q.pop_front();
        act = (e.kind == 0) ? bus.ReadData : {23'h0, bus.tx_valid, bus.tx_data};
        if (act !== e.val) begin
          bad++;
          $display("FAIL %s: got 0x%08h required 0x%08h", e.name, act, e.val);
        end
      end
    end
    if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
      total++;
      if (tx_q.size() == 0) begin
        bad++;
        $display("FAIL tx_unexpected: got 0x%02h required no byte", bus.tx_data);
      end else begin
        eb = tx_q.pop_front();
        if (bus.tx_data !== eb) begin
          bad++;
          $display("FAIL tx_byte: got 0x%02h required 0x%02h", bus.tx_data, eb);
        end
      end
    end
    if (end_chk && !end_done) begin
      total++;
      if (tx_q.size() != 0 || rd_q.size() != 0) begin
        bad++;
        $display("FAIL queues_empty: got tx=%0d rd=%0d required 0 0", tx_q.size(), rd_q.size());
      end
      end_done = 1'b1;
    end
  end

  initial begin
    reset         = 1'b1;
    bus.tx_ready  = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.ALUResult = 32'h0;
    bus.WriteData = 32'h0;

    rst_v = 1'b1;
    idle();
    idle();
    rst_v = 1'b0;

    rd(A_TIMER, 32'h0, "timer_reset");
    rd(A_STAT, 32'h01, "status_reset");
    lvl(32'h0, "tx_reset");
    idle();
    idle();
    rd(A_TIMER, 32'd5, "timer_count");

    wr(A_TIMER, 32'hFFFF_FFFE);
    rd(A_TIMER, 32'hFFFF_FFFE, "timer_load");
    rd(A_TIMER, 32'hFFFF_FFFF, "timer_max");
    rd(A_TIMER, 32'h0, "timer_wrap");

    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_read");
    rd(32'h0000_0110, 32'hDEAD_BEEF, "ram_alias");
    rd(32'h0000_0013, 32'hDEAD_BEEF, "ram_lowbits");

    wr(A_RSV, 32'h1234_5678);
    rd(A_RSV, 32'h0, "reserved_read");
    rd(A_TXD, 32'h0, "txdata_read");

    rdy_v = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h41 + 8'(i));
    rd(A_STAT, 32'h22, "status_full");
    pushx(8'h45);
    rd(A_STAT, 32'h26, "status_ovf");
    wr(A_STAT, 32'h0);
    rd(A_STAT, 32'h22, "status_ovf_clr");
    lvl(32'h141, "tx_head");
    rdy_v = 1'b1;
    for (int i = 0; i < 4; i++) idle();
    lvl(32'h0, "tx_drained");
    rd(A_STAT, 32'h01, "status_drained");

    rdy_v = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h61 + 8'(i));
    rdy_v = 1'b1;
    push(8'h55);
    rdy_v = 1'b0;
    rd(A_STAT, 32'h22, "status_full_swap");
    rdy_v = 1'b1;
    for (int i = 0; i < 4; i++) idle();
    lvl(32'h0, "tx_swap_drained");

    push(8'h81);
    push(8'h82);
    push(8'h83);
    idle();
    lvl(32'h0, "tx_stream_drained");

    rdy_v = 1'b0;
    wr(A_TIMER, 32'd97);
    pushx(8'h71);
    pushx(8'h72);
    pushx(8'h73);
    rst_v = 1'b1;
    pushx(8'h99);
    rst_v = 1'b0;
    rdy_v = 1'b1;
    rd(A_TIMER, 32'h0, "timer_after_rst");
    lvl(32'h0, "tx_after_rst");
    rd(A_STAT, 32'h01, "status_after_rst");
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_kept");

    idle();
    end_chk = 1'b1;
    idle();
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
